// File: rtl/mmio_data_memory.sv
// Word-addressed data memory with a 16-word MMIO window at the top of the address space.
// RAM is zeroed by a post-reset clear sequence; reads are registered with a one-cycle valid strobe.
module mmio_data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     be,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic                    busy,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_event,
  output logic [N_OUT*DATA_W-1:0] out_data
);

  localparam int NB        = DATA_W / 8;
  localparam int MMIO_BASE = 2**ADDR_W - 16;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;

  logic [DATA_W-1:0] ram     [MMIO_BASE];
  logic [DATA_W-1:0] in_reg  [N_IN];
  logic [DATA_W-1:0] out_reg [N_OUT];
  logic [N_IN-1:0]   flags;

  logic              active;
  logic              do_read;
  logic              do_write;
  logic              in_win;
  logic [3:0]        win_off;
  logic [N_IN-1:0]   flag_clr;
  logic [DATA_W-1:0] read_val;

  assign active   = !rst && (state == S_IDLE);
  assign do_read  = active && mem_read;
  assign do_write = active && mem_write;
  assign in_win   = &addr[ADDR_W-1:4];
  assign win_off  = addr[3:0];
  assign busy     = (state == S_CLEAR);

  // Clear sequencer: one RAM word per cycle, restarted from word 0 by any reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else if (state == S_CLEAR) begin
      clr_addr <= clr_addr + ADDR_W'(1);
      if (clr_addr == ADDR_W'(MMIO_BASE - 1)) state <= S_IDLE;
    end
  end

  // NOTE: the RAM array has no reset branch; it is zeroed by the clear sequence so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (!rst && state == S_CLEAR) begin
      ram[clr_addr] <= '0;
    end else if (do_write && !in_win) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) ram[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    flag_clr = '0;
    if (do_write && in_win && win_off == 4'd7 && be[0]) flag_clr = wdata[N_IN-1:0];
  end

  always_comb begin
    read_val = '0;
    if (!in_win) begin
      read_val = ram[addr];
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (win_off == 4'(i)) read_val = in_reg[i];
      if (win_off == 4'd7) read_val[N_IN-1:0] = flags;
      for (int j = 0; j < N_OUT; j++)
        if (win_off == 4'(8 + j)) read_val = out_reg[j];
    end
  end

  // Input sampling and event capture run in both states; set beats a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      flags  <= '0;
      for (int i = 0; i < N_IN; i++)  in_reg[i]  <= '0;
      for (int j = 0; j < N_OUT; j++) out_reg[j] <= '0;
    end else begin
      rvalid <= do_read;
      if (do_read) rdata <= read_val;
      flags <= (flags & ~flag_clr) | in_event;
      for (int i = 0; i < N_IN; i++) in_reg[i] <= in_data[i*DATA_W +: DATA_W];
      for (int j = 0; j < N_OUT; j++)
        for (int b = 0; b < NB; b++)
          if (do_write && in_win && win_off == 4'(8 + j) && be[b])
            out_reg[j][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N_OUT; j++) out_data[j*DATA_W +: DATA_W] = out_reg[j];
  end

endmodule
